// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle instruction control sequencer
// Fetch/decode/execute/memory/writeback FSM with memory-wait timeout and retire counter.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op_code,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        reg_write,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_BRANCH,
    C_JUMP,
    C_LOAD,
    C_STORE,
    C_HALT,
    C_ILLEGAL
  } class_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [3:0] WAIT_LIMIT  = 4'd15;

  function automatic class_t classify(input logic [5:0] op);
    case (op)
      6'd0, 6'd62, 6'd63:                       return C_ALU;
      6'd15, 6'd16, 6'd17, 6'd18, 6'd19,
      6'd21, 6'd22:                             return C_BRANCH;
      6'd20:                                    return C_JUMP;
      6'd61:                                    return C_LOAD;
      6'd60:                                    return C_STORE;
      6'd45:                                    return C_HALT;
      default:                                  return C_ILLEGAL;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] count_q, count_d;

  class_t dec_cls;
  class_t op_cls;

  // DECODE steers on the live opcode; later states use the latched copy.
  assign dec_cls = classify(op_code);
  assign op_cls  = classify(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      wait_q  <= 4'd0;
      err_q   <= ERR_NONE;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        op_d = op_code;
        case (dec_cls)
          C_HALT:    state_d = S_HALT;
          C_ILLEGAL: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_cls)
          C_ALU, C_JUMP:    state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            state_d = S_FETCH;
            count_d = count_q + 16'd1;
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_cls == C_STORE) begin
            state_d = S_FETCH;
            count_d = count_q + 16'd1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        count_d = count_q + 16'd1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Any state change restarts the wait count, so FETCH/MEM always enter at zero.
    if (state_d != state_q) begin
      wait_d = 4'd0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        if ((op_cls == C_BRANCH && branch_taken) || op_cls == C_JUMP) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
        end
      end
      S_MEM: begin
        if (op_cls == C_STORE) mem_write = 1'b1;
        else                   mem_read  = 1'b1;
      end
      S_WB:    reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  op_code;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_read;
  logic        mem_write;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        reg_write;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  err;
  logic [15:0] instr_count;

  multicycle_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_code      (op_code),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .reg_write    (reg_write),
    .state        (state),
    .halted       (halted),
    .err          (err),
    .instr_count  (instr_count)
  );

  typedef struct packed {
    logic       start;
    logic [5:0] op;
    logic       rdy;
    logic       bt;
  } stim_t;

  // Flag order: {mem_read, mem_write, ir_load, pc_write, pc_sel, reg_write}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RD   = 6'b100000;
  localparam logic [5:0] WR   = 6'b010000;
  localparam logic [5:0] PCJ  = 6'b000110;
  localparam logic [5:0] RW   = 6'b000001;
  localparam logic [5:0] FOK  = 6'b101100;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  stim_t       stim_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t st(input logic s, input logic [5:0] op, input logic rdy, input logic bt);
    st = '{start: s, op: op, rdy: rdy, bt: bt};
  endfunction

  function automatic logic [11:0] ev(input logic [2:0] s, input logic [5:0] f, input logic h,
                                     input logic [1:0] e);
    ev = {s, f, h, e};
  endfunction

  function automatic logic [11:0] obs();
    obs = {state, mem_read, mem_write, ir_load, pc_write, pc_sel, reg_write, halted, err};
  endfunction

  task automatic add(input stim_t s, input logic [11:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    start        = s.start;
    op_code      = s.op;
    mem_ready    = s.rdy;
    branch_taken = s.bt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; op_code = 6'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; op_code = 6'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    #1;
    rst_n = 1'b0; start = 1'b1; mem_ready = 1'b1;
    #2;
    vec_cnt++;
    if (obs() !== ev(3'd0, NONE, 1'b0, 2'b00)) begin
      miss_cnt++; $display("FAIL reset_outputs got %h want %h", obs(), ev(3'd0, NONE, 1'b0, 2'b00));
    end
    vec_cnt++;
    if (instr_count !== 16'd0) begin
      miss_cnt++; $display("FAIL reset_count got %0d want 0", instr_count);
    end
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (state !== 3'd0) begin
      miss_cnt++; $display("FAIL reset_hold_state got %0d want 0", state);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    add(st(1'b0, 6'd0, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL idle_hold cyc%0d got %h want %h", i, obs(), exp_v); end
    end
  endtask

  task automatic test_alu();
    do_reset();
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd5, RW,   1'b0, 2'b00));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL alu cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd1) begin
      miss_cnt++; $display("FAIL alu_count got %0d want 1", instr_count);
    end
  endtask

  task automatic test_load();
    do_reset();
    add(st(1'b1, 6'd61, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd61, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd61, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd7,  1'b1, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    for (int k = 0; k < 3; k++) add(st(1'b0, 6'd7, 1'b0, 1'b0), ev(3'd4, RD, 1'b0, 2'b00));
    add(st(1'b0, 6'd7, 1'b1, 1'b0), ev(3'd4, RD, 1'b0, 2'b00));
    add(st(1'b0, 6'd7, 1'b0, 1'b0), ev(3'd5, RW, 1'b0, 2'b00));
    add(st(1'b0, 6'd7, 1'b0, 1'b0), ev(3'd1, RD, 1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL load cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd1) begin
      miss_cnt++; $display("FAIL load_count got %0d want 1", instr_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    add(st(1'b1, 6'd16, 1'b1, 1'b1), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd16, 1'b1, 1'b1), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd16, 1'b1, 1'b1), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b1), ev(3'd3, PCJ,  1'b0, 2'b00));
    add(st(1'b0, 6'd16, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd16, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL branch cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd2) begin
      miss_cnt++; $display("FAIL branch_count got %0d want 2", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add(st(1'b1, 6'd20, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd20, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd20, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd62, 1'b1, 1'b0), ev(3'd3, PCJ,  1'b0, 2'b00));
    add(st(1'b0, 6'd62, 1'b1, 1'b0), ev(3'd5, RW,   1'b0, 2'b00));
    add(st(1'b0, 6'd62, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd62, 1'b1, 1'b1), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd63, 1'b1, 1'b1), ev(3'd3, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd63, 1'b1, 1'b0), ev(3'd5, RW,   1'b0, 2'b00));
    add(st(1'b0, 6'd63, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL b2b cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd2) begin
      miss_cnt++; $display("FAIL b2b_count got %0d want 2", instr_count);
    end
  endtask

  task automatic test_illegal_and_halt();
    do_reset();
    add(st(1'b1, 6'd33, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd33, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd33, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b1, 6'd0,  1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b01));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b01));
    add(st(1'b1, 6'd0,  1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b01));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL illegal cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd0) begin
      miss_cnt++; $display("FAIL illegal_count got %0d want 0", instr_count);
    end
    do_reset();
    add(st(1'b1, 6'd45, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd45, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd45, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b1, 6'd0,  1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b00));
    add(st(1'b1, 6'd0,  1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL halt_op cyc%0d got %h want %h", i, obs(), exp_v); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    add(st(1'b1, 6'd0, 1'b0, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    for (int k = 0; k < 16; k++) add(st(1'b0, 6'd0, 1'b0, 1'b0), ev(3'd1, RD, 1'b0, 2'b00));
    add(st(1'b0, 6'd0, 1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b10));
    add(st(1'b1, 6'd0, 1'b1, 1'b0), ev(3'd6, NONE, 1'b1, 2'b10));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL timeout cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    do_reset();
    add(st(1'b1, 6'd0, 1'b0, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    for (int k = 0; k < 15; k++) add(st(1'b0, 6'd0, 1'b0, 1'b0), ev(3'd1, RD, 1'b0, 2'b00));
    add(st(1'b0, 6'd0, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd0, 1'b0, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0, 1'b0, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL ready_wins cyc%0d got %h want %h", i, obs(), exp_v); end
    end
  endtask

  task automatic test_store_reset();
    do_reset();
    add(st(1'b1, 6'd60, 1'b1, 1'b0), ev(3'd0, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd60, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd60, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd4, WR,   1'b0, 2'b00));
    add(st(1'b0, 6'd60, 1'b1, 1'b0), ev(3'd1, FOK,  1'b0, 2'b00));
    add(st(1'b0, 6'd60, 1'b1, 1'b0), ev(3'd2, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b1, 1'b0), ev(3'd3, NONE, 1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b0, 1'b0), ev(3'd4, WR,   1'b0, 2'b00));
    add(st(1'b0, 6'd0,  1'b0, 1'b0), ev(3'd4, WR,   1'b0, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); exp_v = exp_q.pop_front(); vec_cnt++;
      if (obs() !== exp_v) begin miss_cnt++; $display("FAIL store cyc%0d got %h want %h", i, obs(), exp_v); end
    end
    vec_cnt++;
    if (instr_count !== 16'd1) begin
      miss_cnt++; $display("FAIL store_count got %0d want 1", instr_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (mem_write !== 1'b0 || state !== 3'd0) begin
      miss_cnt++; $display("FAIL async_drop mem_write=%b state=%0d want 0/0", mem_write, state);
    end
    vec_cnt++;
    if (instr_count !== 16'd0 || err !== 2'b00) begin
      miss_cnt++; $display("FAIL async_clear count=%0d err=%b want 0/00", instr_count, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_back_to_back();
    test_illegal_and_halt();
    test_timeout();
    test_store_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
